// File: rtl/tick_period_meter.sv
// tick_period_meter: measures clk cycles between successive rising edges of `in`.
// Latency: result registered on the edge capturing the second rise (+2 cycles with TICK_PERIOD_METER_SYNC_EN).
// Backpressure: one-entry valid/ready output; results arriving while occupied are dropped (sticky `dropped`).
module tick_period_meter #(
  parameter int CNT_WIDTH = 16
) (
  input  logic                 clk,
  input  logic                 rst_n,
  input  logic                 in,
  output logic [CNT_WIDTH-1:0] period,
  output logic                 timeout,
  output logic                 valid,
  input  logic                 ready,
  output logic                 dropped
);

  localparam logic [CNT_WIDTH-1:0] CNT_MAX  = '1;
  localparam logic [CNT_WIDTH-1:0] CNT_ONE  = CNT_WIDTH'(1);
  localparam logic [CNT_WIDTH-1:0] CNT_ZERO = '0;

  typedef enum logic {
    WAIT_FIRST = 1'b0,
    COUNT      = 1'b1
  } state_e;

  // Conditioned input
  logic s;

`ifdef TICK_PERIOD_METER_SYNC_EN
  logic sync1_q, sync1_d;
  logic sync2_q, sync2_d;

  // Two-stage synchronizer next values: plain shift of the raw input
  always_comb begin
    sync1_d = in;
    sync2_d = sync1_q;
  end

  // Synchronizer flops, cleared by reset so no phantom edge follows reset
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      sync1_q <= 1'b0;
      sync2_q <= 1'b0;
    end else begin
      sync1_q <= sync1_d;
      sync2_q <= sync2_d;
    end
  end

  assign s = sync2_q;
`else
  assign s = in;
`endif

  // Edge detector and measurement state
  logic                 s_d_q, s_d_d;
  logic                 rise;
  state_e               state_q, state_d;
  logic [CNT_WIDTH-1:0] cnt_q, cnt_d;

  // Output register state
  logic [CNT_WIDTH-1:0] period_q, period_d;
  logic                 timeout_q, timeout_d;
  logic                 valid_q, valid_d;
  logic                 dropped_q, dropped_d;

  // Result produced this cycle (not yet committed to the output register)
  logic                 res_vld;
  logic [CNT_WIDTH-1:0] res_period;
  logic                 res_timeout;

  assign rise = s & ~s_d_q;

  // Measurement FSM: counts cycles between rises, saturates into a timeout result
  always_comb begin
    s_d_d       = s;
    state_d     = state_q;
    cnt_d       = cnt_q;
    res_vld     = 1'b0;
    res_period  = CNT_ZERO;
    res_timeout = 1'b0;
    case (state_q)
      WAIT_FIRST: begin
        cnt_d = CNT_ZERO;
        if (rise) begin
          // First edge only arms the meter
          cnt_d   = CNT_ONE;
          state_d = COUNT;
        end
      end
      COUNT: begin
        if (rise) begin
          // A rise wins over saturation, so a full-scale period still reads as a normal result
          res_vld     = 1'b1;
          res_period  = cnt_q;
          res_timeout = 1'b0;
          cnt_d       = CNT_ONE;
        end else if (cnt_q == CNT_MAX) begin
          res_vld     = 1'b1;
          res_period  = CNT_MAX;
          res_timeout = 1'b1;
          cnt_d       = CNT_ZERO;
          state_d     = WAIT_FIRST;
        end else begin
          cnt_d = cnt_q + CNT_ONE;
        end
      end
      default: begin
        cnt_d   = CNT_ZERO;
        state_d = WAIT_FIRST;
      end
    endcase
  end

  // Output register: load when free or being drained, else drop and flag
  always_comb begin
    period_d  = period_q;
    timeout_d = timeout_q;
    valid_d   = valid_q;
    dropped_d = dropped_q;
    if (res_vld) begin
      if (!valid_q || ready) begin
        period_d  = res_period;
        timeout_d = res_timeout;
        valid_d   = 1'b1;
      end else begin
        dropped_d = 1'b1;
      end
    end else if (valid_q && ready) begin
      valid_d = 1'b0;
    end
  end

  // All state registers with synchronous active-low reset
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      s_d_q     <= 1'b0;
      state_q   <= WAIT_FIRST;
      cnt_q     <= CNT_ZERO;
      period_q  <= CNT_ZERO;
      timeout_q <= 1'b0;
      valid_q   <= 1'b0;
      dropped_q <= 1'b0;
    end else begin
      s_d_q     <= s_d_d;
      state_q   <= state_d;
      cnt_q     <= cnt_d;
      period_q  <= period_d;
      timeout_q <= timeout_d;
      valid_q   <= valid_d;
      dropped_q <= dropped_d;
    end
  end

  assign period  = period_q;
  assign timeout = timeout_q;
  assign valid   = valid_q;
  assign dropped = dropped_q;

endmodule

// File: tb/tb_tick_period_meter.sv
// Bench for tick_period_meter: a 16-bit and a 4-bit instance share stimulus
// and are checked every cycle against a timestamp-based reference model.
module tb_tick_period_meter;

  logic        clk = 1'b0;
  logic        rst_n;
  logic        in_s;
  logic        ready_s;

  logic [15:0] p16;
  logic        t16, v16, d16;
  logic [3:0]  p4;
  logic        t4, v4, d4;

  int checks = 0;
  int errors = 0;

  always #5 clk = ~clk;

  tick_period_meter #(.CNT_WIDTH(16)) dut16 (
    .clk(clk), .rst_n(rst_n), .in(in_s),
    .period(p16), .timeout(t16), .valid(v16), .ready(ready_s), .dropped(d16)
  );

  tick_period_meter #(.CNT_WIDTH(4)) dut4 (
    .clk(clk), .rst_n(rst_n), .in(in_s),
    .period(p4), .timeout(t4), .valid(v4), .ready(ready_s), .dropped(d4)
  );

`ifdef TICK_PERIOD_METER_SYNC_EN
  localparam int LAT = 2;
`else
  localparam int LAT = 0;
`endif

  // Reference model: conditioned-input history plus, per instance, the
  // timestamp of the last arming/measuring edge.
  int   cyc_n = 0;
  logic y1 = 1'b0, y2 = 1'b0, s_prev = 1'b0;
  int   maxv  [2];
  logic armed [2];
  int   t_arm [2];
  logic m_vld [2];
  int   m_per [2];
  logic m_tmo [2];
  logic m_drp [2];

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s @cycle %0d observed=%0h expected=%0h", tag, cyc_n, obs, exp);
    end
  endtask

  task automatic model_edge(input logic i, input logic r, input logic rn);
    logic s, rise, res, rt;
    int   rp, el;
    s    = (LAT == 0) ? i : y2;
    rise = s && !s_prev;
    for (int k = 0; k < 2; k++) begin
      if (!rn) begin
        armed[k] = 1'b0; m_vld[k] = 1'b0; m_per[k] = 0;
        m_tmo[k] = 1'b0; m_drp[k] = 1'b0;
      end else begin
        res = 1'b0; rp = 0; rt = 1'b0;
        if (armed[k]) begin
          el = cyc_n - t_arm[k];
          if (rise) begin
            res = 1'b1; rp = el; rt = 1'b0; t_arm[k] = cyc_n;
          end else if (el == maxv[k]) begin
            res = 1'b1; rp = maxv[k]; rt = 1'b1; armed[k] = 1'b0;
          end
        end else if (rise) begin
          armed[k] = 1'b1; t_arm[k] = cyc_n;
        end
        if (res) begin
          if (!m_vld[k] || r) begin
            m_vld[k] = 1'b1; m_per[k] = rp; m_tmo[k] = rt;
          end else begin
            m_drp[k] = 1'b1;
          end
        end else if (m_vld[k] && r) begin
          m_vld[k] = 1'b0;
        end
      end
    end
    if (!rn) begin
      y1 = 1'b0; y2 = 1'b0; s_prev = 1'b0;
    end else begin
      y2 = y1; y1 = i; s_prev = s;
    end
    cyc_n++;
  endtask

  task automatic compare_all();
    chk("valid16",   32'(v16), 32'(m_vld[0]));
    chk("dropped16", 32'(d16), 32'(m_drp[0]));
    chk("period16",  32'(p16), 32'(m_per[0]));
    chk("timeout16", 32'(t16), 32'(m_tmo[0]));
    chk("valid4",    32'(v4),  32'(m_vld[1]));
    chk("dropped4",  32'(d4),  32'(m_drp[1]));
    chk("period4",   32'(p4),  32'(m_per[1]));
    chk("timeout4",  32'(t4),  32'(m_tmo[1]));
  endtask

  // One clock: drive inputs, advance model at the edge, check on the falling edge
  task automatic step(input logic i, input logic r, input logic rn);
    in_s = i; ready_s = r; rst_n = rn;
    @(posedge clk);
    model_edge(i, r, rn);
    @(negedge clk);
    compare_all();
  endtask

  task automatic strobe(input int gap, input logic r);
    step(1'b1, r, 1'b1);
    for (int j = 1; j < gap; j++) step(1'b0, r, 1'b1);
  endtask

  initial begin
    int gap, hi;
    maxv[0] = 65535; maxv[1] = 15;
    for (int k = 0; k < 2; k++) begin
      armed[k] = 1'b0; t_arm[k] = 0; m_vld[k] = 1'b0;
      m_per[k] = 0; m_tmo[k] = 1'b0; m_drp[k] = 1'b0;
    end
    in_s = 1'b0; ready_s = 1'b0; rst_n = 1'b0;
    @(negedge clk);

    // Reset state
    step(1'b0, 1'b0, 1'b0);
    step(1'b0, 1'b0, 1'b0);
    chk("reset_valid16", 32'(v16), 32'd0);
    chk("reset_period4", 32'(p4), 32'd0);

    // Strobe every 4 cycles, always ready
    for (int n = 0; n < 6; n++) strobe(4, 1'b1);
    chk("strobe4_period16", 32'(p16), 32'd4);

    // Square wave 5 high / 5 low
    for (int n = 0; n < 4; n++) begin
      for (int j = 0; j < 5; j++) step(1'b1, 1'b1, 1'b1);
      for (int j = 0; j < 5; j++) step(1'b0, 1'b1, 1'b1);
    end
    chk("square10_period16", 32'(p16), 32'd10);

    // Long low: 4-bit instance saturates into a timeout, then re-arms
    for (int j = 0; j < 25; j++) step(1'b0, 1'b1, 1'b1);
    chk("timeout4_flag", 32'(t4), 32'd1);
    chk("timeout4_period", 32'(p4), 32'hf);
    for (int n = 0; n < 3; n++) strobe(15, 1'b1);
    chk("rise_beats_sat_timeout4", 32'(t4), 32'd0);
    chk("rise_beats_sat_period4", 32'(p4), 32'hf);

    // Backpressure: hold results, then drain with back-to-back replacement
    for (int n = 0; n < 4; n++) strobe(4, 1'b0);
    chk("bp_dropped16", 32'(d16), 32'd1);
    for (int n = 0; n < 4; n++) strobe(4, 1'b1);

    // Reset mid-measurement
    step(1'b1, 1'b1, 1'b1);
    step(1'b0, 1'b1, 1'b1);
    step(1'b0, 1'b1, 1'b0);
    chk("midreset_dropped16", 32'(d16), 32'd0);
    for (int n = 0; n < 4; n++) strobe(6, 1'b1);

    // Constant high input: no edges, 4-bit instance times out
    for (int j = 0; j < 20; j++) step(1'b1, 1'b1, 1'b1);
    step(1'b0, 1'b1, 1'b1);

    // Randomized gaps, duty and ready
    for (int n = 0; n < 60; n++) begin
      gap = $urandom_range(2, 20);
      hi  = $urandom_range(1, gap - 1);
      for (int j = 0; j < gap; j++)
        step((j < hi) ? 1'b1 : 1'b0, ($urandom_range(0, 3) != 0) ? 1'b1 : 1'b0, 1'b1);
    end

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
